// File: rtl/dcache_pkg.sv
// Shared L1 D-cache definitions: geometry, store-port state encoding and
// word-address field extraction used by the store port, load pipe and refill unit.
package dcache_pkg;

    localparam int unsigned DC_PHYS       = 32;
    localparam int unsigned DC_SET_BITS   = 6;
    localparam int unsigned DC_WORD_BITS  = 2;
    localparam int unsigned DC_WAYS       = 2;
    localparam int unsigned DC_WADDR_W    = DC_PHYS - 2;
    localparam int unsigned DC_TAGW       = DC_PHYS - 2 - DC_SET_BITS - DC_WORD_BITS;
    localparam int unsigned DC_LINE_BYTES = 4 << DC_WORD_BITS;

    typedef enum logic [2:0] {
        IDLE,
        TAGREQ,
        TAGCMP,
        BUSREQ,
        BUSWAIT,
        DONE
    } store_state_e;

    typedef logic [DC_WADDR_W-1:0] waddr_t;

    function automatic logic [DC_TAGW-1:0] addr_tag(input waddr_t a);
        return a[DC_WADDR_W-1 -: DC_TAGW];
    endfunction

    function automatic logic [DC_SET_BITS-1:0] addr_index(input waddr_t a);
        return a[DC_WORD_BITS +: DC_SET_BITS];
    endfunction

    function automatic logic [DC_WORD_BITS-1:0] addr_word(input waddr_t a);
        return a[DC_WORD_BITS-1:0];
    endfunction

endpackage

// File: rtl/dcache_way_match.sv
// Parallel tag compare across all ways of one set: one-hot hit vector plus any-hit.
module dcache_way_match
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS = DC_WAYS,
    parameter int unsigned TAGW = DC_TAGW
) (
    input  logic [WAYS*TAGW-1:0] tags,
    input  logic [WAYS-1:0]      valid,
    input  logic [TAGW-1:0]      tag,
    output logic [WAYS-1:0]      hit_vec,
    output logic                 any_hit
);

    always_comb begin
        hit_vec = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[w] && (tags[w*TAGW +: TAGW] == tag);
        end
    end

    assign any_hit = |hit_vec;

endmodule

// File: rtl/dcache_store_port.sv
// Store-buffer drain responder: tag lookup, write-through data update on hit, bus write.
// Define STORE_POSTED_WRITE_EN to retire stores on bus grant with up to 3 writes outstanding.
module dcache_store_port
    import dcache_pkg::*;
#(
    parameter int unsigned PHYS      = DC_PHYS,
    parameter int unsigned SET_BITS  = DC_SET_BITS,
    parameter int unsigned WORD_BITS = DC_WORD_BITS,
    parameter int unsigned WAYS      = DC_WAYS
) (
    input  logic                                 cpu_clk_i,
    input  logic                                 cpu_rst_i,
    input  logic                                 store_valid_i,
    input  logic [PHYS-3:0]                      store_address_i,
    input  logic [31:0]                          store_data_i,
    input  logic [3:0]                           store_bm_i,
    output logic                                 cache_done_o,
    output logic                                 tag_rd_en_o,
    input  logic                                 tag_rd_gnt_i,
    output logic [SET_BITS-1:0]                  tag_rd_idx_o,
    input  logic [WAYS*(PHYS-2-SET_BITS-WORD_BITS)-1:0] tag_rd_tags_i,
    input  logic [WAYS-1:0]                      tag_rd_valid_i,
    output logic                                 data_wr_en_o,
    output logic [WAYS-1:0]                      data_wr_way_o,
    output logic [SET_BITS+WORD_BITS-1:0]        data_wr_idx_o,
    output logic [31:0]                          data_wr_data_o,
    output logic [3:0]                           data_wr_bm_o,
    output logic                                 mem_req_o,
    output logic [PHYS-3:0]                      mem_addr_o,
    output logic [31:0]                          mem_data_o,
    output logic [3:0]                           mem_bm_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_ack_i,
    output logic                                 mem_idle_o
);

    localparam int unsigned AW   = PHYS - 2;
    localparam int unsigned TAGW = PHYS - 2 - SET_BITS - WORD_BITS;

    store_state_e    state;
    logic [AW-1:0]   req_addr;
    logic [31:0]     req_data;
    logic [3:0]      req_bm;
    logic [WAYS-1:0] hit_vec;
    logic            any_hit;
    logic            can_launch;

    dcache_way_match #(
        .WAYS (WAYS),
        .TAGW (TAGW)
    ) u_way_match (
        .tags    (tag_rd_tags_i),
        .valid   (tag_rd_valid_i),
        .tag     (req_addr[AW-1 -: TAGW]),
        .hit_vec (hit_vec),
        .any_hit (any_hit)
    );

`ifdef STORE_POSTED_WRITE_EN
    logic [1:0] out_cnt;

    // Grant and ack in the same cycle belong to different writes and cancel out.
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            out_cnt <= '0;
        end else begin
            case ({mem_req_o && mem_gnt_i, mem_ack_i})
                2'b10:   out_cnt <= out_cnt + 2'd1;
                2'b01:   out_cnt <= out_cnt - 2'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign can_launch = (out_cnt != 2'd3);
    assign mem_idle_o = (out_cnt == 2'd0);
`else
    assign can_launch = 1'b1;
    assign mem_idle_o = (state == IDLE);
`endif

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            state         <= IDLE;
            cache_done_o  <= 1'b0;
            tag_rd_en_o   <= 1'b0;
            data_wr_en_o  <= 1'b0;
            data_wr_way_o <= '0;
            mem_req_o     <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            req_bm        <= '0;
        end else begin
            cache_done_o <= 1'b0;
            data_wr_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (store_valid_i && !cache_done_o && can_launch) begin
                        req_addr    <= store_address_i;
                        req_data    <= store_data_i;
                        req_bm      <= store_bm_i;
                        tag_rd_en_o <= 1'b1;
                        state       <= TAGREQ;
                    end
                end
                TAGREQ: begin
                    if (tag_rd_gnt_i) begin
                        tag_rd_en_o <= 1'b0;
                        state       <= TAGCMP;
                    end
                end
                TAGCMP: begin
                    data_wr_en_o  <= any_hit;
                    data_wr_way_o <= hit_vec;
                    mem_req_o     <= 1'b1;
                    state         <= BUSREQ;
                end
                BUSREQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
`ifdef STORE_POSTED_WRITE_EN
                        cache_done_o <= 1'b1;
                        state        <= DONE;
`else
                        if (mem_ack_i) begin
                            cache_done_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= BUSWAIT;
                        end
`endif
                    end
                end
                BUSWAIT: begin
                    if (mem_ack_i) begin
                        cache_done_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A line may live in at most one way; multiple matches mean corrupted tags.
    always_ff @(posedge cpu_clk_i) begin
        if (!cpu_rst_i && state == TAGCMP) begin
            assert ($onehot0(hit_vec));
        end
    end

    assign tag_rd_idx_o   = req_addr[WORD_BITS +: SET_BITS];
    assign data_wr_idx_o  = req_addr[SET_BITS+WORD_BITS-1:0];
    assign data_wr_data_o = req_data;
    assign data_wr_bm_o   = req_bm;
    assign mem_addr_o     = req_addr;
    assign mem_data_o     = req_data;
    assign mem_bm_o       = req_bm;

endmodule

// File: tb/tb_dcache_store_port.sv
// Randomized bench for dcache_store_port against a tag-array model and a latency formula.
module tb_dcache_store_port;

    localparam int PHYS      = 32;
    localparam int SET_BITS  = 6;
    localparam int WORD_BITS = 2;
    localparam int WAYS      = 2;
    localparam int AW        = PHYS - 2;
    localparam int TAGW      = PHYS - 2 - SET_BITS - WORD_BITS;
    localparam int NSETS     = 1 << SET_BITS;
`ifdef STORE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic                          cpu_clk_i;
    logic                          cpu_rst_i;
    logic                          store_valid_i;
    logic [AW-1:0]                 store_address_i;
    logic [31:0]                   store_data_i;
    logic [3:0]                    store_bm_i;
    logic                          cache_done_o;
    logic                          tag_rd_en_o;
    logic                          tag_rd_gnt_i;
    logic [SET_BITS-1:0]           tag_rd_idx_o;
    logic [WAYS*TAGW-1:0]          tag_rd_tags_i;
    logic [WAYS-1:0]               tag_rd_valid_i;
    logic                          data_wr_en_o;
    logic [WAYS-1:0]               data_wr_way_o;
    logic [SET_BITS+WORD_BITS-1:0] data_wr_idx_o;
    logic [31:0]                   data_wr_data_o;
    logic [3:0]                    data_wr_bm_o;
    logic                          mem_req_o;
    logic [AW-1:0]                 mem_addr_o;
    logic [31:0]                   mem_data_o;
    logic [3:0]                    mem_bm_o;
    logic                          mem_gnt_i;
    logic                          mem_ack_i;
    logic                          mem_idle_o;

    int vectors = 0;
    int miscompares = 0;

    logic [TAGW-1:0] mtag [NSETS][WAYS];
    logic            mval [NSETS][WAYS];

    dcache_store_port #(
        .PHYS      (PHYS),
        .SET_BITS  (SET_BITS),
        .WORD_BITS (WORD_BITS),
        .WAYS      (WAYS)
    ) dut (
        .cpu_clk_i       (cpu_clk_i),
        .cpu_rst_i       (cpu_rst_i),
        .store_valid_i   (store_valid_i),
        .store_address_i (store_address_i),
        .store_data_i    (store_data_i),
        .store_bm_i      (store_bm_i),
        .cache_done_o    (cache_done_o),
        .tag_rd_en_o     (tag_rd_en_o),
        .tag_rd_gnt_i    (tag_rd_gnt_i),
        .tag_rd_idx_o    (tag_rd_idx_o),
        .tag_rd_tags_i   (tag_rd_tags_i),
        .tag_rd_valid_i  (tag_rd_valid_i),
        .data_wr_en_o    (data_wr_en_o),
        .data_wr_way_o   (data_wr_way_o),
        .data_wr_idx_o   (data_wr_idx_o),
        .data_wr_data_o  (data_wr_data_o),
        .data_wr_bm_o    (data_wr_bm_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_bm_o        (mem_bm_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_ack_i       (mem_ack_i),
        .mem_idle_o      (mem_idle_o)
    );

    initial begin
        cpu_clk_i = 1'b0;
        forever #5 cpu_clk_i = ~cpu_clk_i;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1);
    end

    // Fill one set of the model: mode 0/1 hit in that way, 2 matching tag but invalid, 3 no match.
    task automatic prep_set(input logic [AW-1:0] addr, input int mode);
        logic [SET_BITS-1:0] idx;
        logic [TAGW-1:0]     tg;
        int                  w;
        idx = addr[WORD_BITS +: SET_BITS];
        tg  = addr[AW-1 -: TAGW];
        for (int i = 0; i < WAYS; i++) begin
            mval[idx][i] = 1'($urandom);
            mtag[idx][i] = tg ^ TAGW'($urandom_range(1, 'hFFFF));
        end
        w = $urandom_range(0, WAYS-1);
        if (mode <= 1) begin
            mval[idx][mode] = 1'b1;
            mtag[idx][mode] = tg;
        end else if (mode == 2) begin
            mval[idx][w] = 1'b0;
            mtag[idx][w] = tg;
        end
    endtask

    function automatic int model_hit_way(input logic [AW-1:0] addr);
        logic [SET_BITS-1:0] idx;
        idx = addr[WORD_BITS +: SET_BITS];
        for (int w = 0; w < WAYS; w++) begin
            if (mval[idx][w] && mtag[idx][w] == addr[AW-1 -: TAGW]) return w;
        end
        return -1;
    endfunction

    // Drive one store and play tag-port and bus responder; ackd < 0 withholds the ack.
    // Returns at the falling edge of the expected done cycle with store_valid_i still high.
    task automatic run_store(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] bm, input int tstall, input int mstall,
                             input int ackd);
        int                  hw, ack_d, exp_done, tseen, mseen, gcyc;
        bit                  granted_prev;
        logic [SET_BITS-1:0] idx;
        logic [3:0]          exp_hs, got_hs;
        logic [WAYS-1:0]     exp_way;
        idx   = addr[WORD_BITS +: SET_BITS];
        hw    = model_hit_way(addr);
        ack_d = ackd;
        if (POSTED && ack_d > 0) ack_d = 0;
        exp_done = 4 + tstall + mstall + (POSTED ? 0 : ack_d);
        exp_way  = (hw >= 0) ? WAYS'(1 << hw) : '0;
        store_valid_i   = 1'b1;
        store_address_i = addr;
        store_data_i    = data;
        store_bm_i      = bm;
        tag_rd_gnt_i    = 1'b0;
        mem_gnt_i       = 1'b0;
        mem_ack_i       = 1'b0;
        tseen = 0; mseen = 0; gcyc = -1; granted_prev = 1'b0;
        for (int c = 1; c <= exp_done; c++) begin
            @(negedge cpu_clk_i);
            exp_hs = {c <= 1 + tstall,
                      c >= 3 + tstall && c <= 3 + tstall + mstall,
                      hw >= 0 && c == 3 + tstall,
                      c == exp_done};
            got_hs = {tag_rd_en_o, mem_req_o, data_wr_en_o, cache_done_o};
            vectors++;
            if (got_hs !== exp_hs) begin
                miscompares++;
                $display("FAIL handshake addr=%h cyc=%0d {tag_en,mem_req,dwr_en,done} got=%b want=%b",
                         addr, c, got_hs, exp_hs);
            end
            if (tag_rd_en_o) begin
                vectors++;
                if (tag_rd_idx_o !== idx) begin
                    miscompares++;
                    $display("FAIL tag_idx cyc=%0d got=%h want=%h", c, tag_rd_idx_o, idx);
                end
            end
            if (mem_req_o) begin
                vectors++;
                if ({mem_addr_o, mem_data_o, mem_bm_o} !== {addr, data, bm}) begin
                    miscompares++;
                    $display("FAIL bus_payload cyc=%0d got=%h/%h/%b want=%h/%h/%b",
                             c, mem_addr_o, mem_data_o, mem_bm_o, addr, data, bm);
                end
            end
            if (data_wr_en_o) begin
                vectors++;
                if ({data_wr_way_o, data_wr_idx_o, data_wr_data_o, data_wr_bm_o} !==
                    {exp_way, addr[SET_BITS+WORD_BITS-1:0], data, bm}) begin
                    miscompares++;
                    $display("FAIL array_write cyc=%0d got=%b/%h/%h/%b want=%b/%h/%h/%b",
                             c, data_wr_way_o, data_wr_idx_o, data_wr_data_o, data_wr_bm_o,
                             exp_way, addr[SET_BITS+WORD_BITS-1:0], data, bm);
                end
            end
            if (!POSTED) begin
                vectors++;
                if (mem_idle_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_idle cyc=%0d got=%b want=0", c, mem_idle_o);
                end
            end
            if (granted_prev) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_rd_tags_i[w*TAGW +: TAGW] = mtag[idx][w];
                    tag_rd_valid_i[w]             = mval[idx][w];
                end
            end else begin
                tag_rd_tags_i  = {WAYS{TAGW'($urandom)}};
                tag_rd_valid_i = WAYS'($urandom);
            end
            granted_prev = 1'b0;
            if (tag_rd_en_o) begin
                if (tseen < tstall) begin
                    tag_rd_gnt_i = 1'b0;
                    tseen++;
                end else begin
                    tag_rd_gnt_i = 1'b1;
                    granted_prev = 1'b1;
                end
            end else begin
                tag_rd_gnt_i = 1'($urandom);
            end
            mem_gnt_i = 1'b0;
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
                if (mseen < mstall) begin
                    mseen++;
                end else begin
                    mem_gnt_i = 1'b1;
                    mem_ack_i = (ack_d == 0);
                    gcyc      = c;
                end
            end else if (ack_d > 0 && gcyc >= 0 && c == gcyc + ack_d) begin
                mem_ack_i = 1'b1;
            end
            store_address_i = AW'($urandom);
            store_data_i    = $urandom;
            store_bm_i      = 4'($urandom);
        end
        tag_rd_gnt_i = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_ack_i    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        store_valid_i = 1'b0;
        tag_rd_gnt_i  = 1'b0;
        mem_gnt_i     = 1'b0;
        mem_ack_i     = 1'b0;
        repeat (n) begin
            @(negedge cpu_clk_i);
            vectors++;
            if ({tag_rd_en_o, mem_req_o, data_wr_en_o, cache_done_o, mem_idle_o} !== 5'b00001) begin
                miscompares++;
                $display("FAIL quiet {tag_en,mem_req,dwr_en,done,idle} got=%b want=00001",
                         {tag_rd_en_o, mem_req_o, data_wr_en_o, cache_done_o, mem_idle_o});
            end
        end
    endtask

    task automatic test_reset();
        cpu_rst_i       = 1'b1;
        store_valid_i   = 1'b0;
        store_address_i = '0;
        store_data_i    = '0;
        store_bm_i      = '0;
        tag_rd_gnt_i    = 1'b0;
        tag_rd_tags_i   = '0;
        tag_rd_valid_i  = '0;
        mem_gnt_i       = 1'b0;
        mem_ack_i       = 1'b0;
        repeat (3) @(negedge cpu_clk_i);
        vectors++;
        if ({tag_rd_en_o, mem_req_o, data_wr_en_o, cache_done_o, mem_idle_o} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_state {tag_en,mem_req,dwr_en,done,idle} got=%b want=00001",
                     {tag_rd_en_o, mem_req_o, data_wr_en_o, cache_done_o, mem_idle_o});
        end
        cpu_rst_i = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_hit();
        mval[4][1] = 1'b1; mtag[4][1] = 22'h040000;
        mval[4][0] = 1'b1; mtag[4][0] = 22'h040001;
        run_store(30'h0400_0010, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0);
        @(negedge cpu_clk_i);
        idle_cycles(2);
    endtask

    task automatic test_miss();
        logic [AW-1:0] a;
        a = 30'h0234_5678;
        mval[a[7:2]][0] = 1'b0; mtag[a[7:2]][0] = a[AW-1 -: TAGW];
        mval[a[7:2]][1] = 1'b1; mtag[a[7:2]][1] = a[AW-1 -: TAGW] ^ 22'h1;
        run_store(a, 32'h0BAD_F00D, 4'b1100, 0, 0, 2);
        @(negedge cpu_clk_i);
        idle_cycles(2);
    endtask

    task automatic test_arb_stall();
        logic [AW-1:0] a;
        a = AW'($urandom);
        prep_set(a, 1);
        run_store(a, $urandom, 4'b1111, 5, 3, 0);
        @(negedge cpu_clk_i);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        for (int i = 0; i < 3; i++) begin
            a = AW'($urandom);
            prep_set(a, (i == 1) ? 3 : i);
            run_store(a, $urandom, 4'($urandom), i, 0, i);
            @(negedge cpu_clk_i);
        end
        idle_cycles(4);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom);
            prep_set(a, $urandom_range(0, 3));
            run_store(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            @(negedge cpu_clk_i);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        store_valid_i   = 1'b1;
        store_address_i = AW'($urandom);
        store_data_i    = $urandom;
        store_bm_i      = 4'hF;
        tag_rd_valid_i  = '0;
        tag_rd_gnt_i    = 1'b1;
        mem_gnt_i       = 1'b1;
        mem_ack_i       = 1'b0;
        repeat (4) @(negedge cpu_clk_i);
        vectors++;
        if ({mem_req_o, cache_done_o, mem_idle_o} !== {1'b0, POSTED, 1'b0}) begin
            miscompares++;
            $display("FAIL await_ack {mem_req,done,idle} got=%b want=%b",
                     {mem_req_o, cache_done_o, mem_idle_o}, {1'b0, POSTED, 1'b0});
        end
        cpu_rst_i     = 1'b1;
        store_valid_i = 1'b0;
        tag_rd_gnt_i  = 1'b0;
        mem_gnt_i     = 1'b0;
        @(negedge cpu_clk_i);
        vectors++;
        if ({tag_rd_en_o, mem_req_o, data_wr_en_o, cache_done_o, mem_idle_o} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_mid {tag_en,mem_req,dwr_en,done,idle} got=%b want=00001",
                     {tag_rd_en_o, mem_req_o, data_wr_en_o, cache_done_o, mem_idle_o});
        end
        cpu_rst_i = 1'b0;
        a = AW'($urandom);
        prep_set(a, 0);
        run_store(a, $urandom, 4'b0101, 1, 1, 1);
        @(negedge cpu_clk_i);
        idle_cycles(2);
    endtask

`ifdef STORE_POSTED_WRITE_EN
    task automatic test_posted();
        logic [AW-1:0] a [4];
        logic [31:0]   d [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = AW'($urandom);
            d[i] = $urandom;
        end
        for (int i = 0; i < 3; i++) begin
            prep_set(a[i], $urandom_range(0, 3));
            run_store(a[i], d[i], 4'hF, 0, 0, -1);
            @(negedge cpu_clk_i);
        end
        prep_set(a[3], 1);
        store_address_i = a[3];
        store_data_i    = d[3];
        store_bm_i      = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge cpu_clk_i);
            vectors++;
            if ({tag_rd_en_o, mem_req_o, cache_done_o, mem_idle_o} !== 4'b0000) begin
                miscompares++;
                $display("FAIL posted_stall cyc=%0d {tag_en,mem_req,done,idle} got=%b want=0000",
                         c, {tag_rd_en_o, mem_req_o, cache_done_o, mem_idle_o});
            end
        end
        mem_ack_i = 1'b1;
        @(negedge cpu_clk_i);
        mem_ack_i = 1'b0;
        vectors++;
        if (tag_rd_en_o !== 1'b0) begin
            miscompares++;
            $display("FAIL posted_release_early got tag_en=%b want=0", tag_rd_en_o);
        end
        run_store(a[3], d[3], 4'hF, 0, 0, -1);
        @(negedge cpu_clk_i);
        store_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem_idle_o !== 1'b0) begin
                miscompares++;
                $display("FAIL posted_outstanding left=%0d got idle=%b want=0", 3 - i, mem_idle_o);
            end
            mem_ack_i = 1'b1;
            @(negedge cpu_clk_i);
        end
        mem_ack_i = 1'b0;
        idle_cycles(3);
    endtask
`endif

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_arb_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef STORE_POSTED_WRITE_EN
        test_posted();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
